// File: rtl/sdio_func_sram_ctrl.sv
// SDIO per-function SRAM access controller.
// Serves single-byte CMD52/CMD53 accesses to one of NUM_FUNC SRAM banks.
// Each access runs SETUP -> ACCESS (WAIT_CYCLES) -> DONE, and ack/err are
// reported one cycle after DONE. Every output is registered.
module sdio_func_sram_ctrl #(
  parameter int NUM_FUNC    = 7,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   cmd52_53_func_num,
  input  logic [NUM_FUNC-1:0]          io_en_func,
  input  logic                         sram_onn,
  input  logic                         req,
  input  logic                         wr,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic                         busy,
  output logic                         ack,
  output logic                         err,
  output logic [DATA_W-1:0]            rdata,
  output logic [NUM_FUNC-1:0]          sram_csn,
  output logic                         sram_wen,
  output logic                         sram_oen,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_dout,
  input  logic [NUM_FUNC*DATA_W-1:0]   sram_din
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                wr_q;
  logic [2:0]          func_q;
  logic                err_q;

  logic                req_valid;
  logic [NUM_FUNC-1:0] csn_dec;
  logic [DATA_W-1:0]   rd_sel;

  // Decode the incoming function number into a chip-select pattern and a validity flag.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    req_valid = 1'b0;
    csn_dec   = '1;
    for (int k = 0; k < NUM_FUNC; k++) begin
      if (cmd52_53_func_num == 3'(k + 1)) begin
        csn_dec[k] = 1'b0;
        req_valid  = io_en_func[k];
      end
    end
    if (sram_onn) req_valid = 1'b0;
  end

  // Select the read data of the bank latched with the request.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_FUNC; k++) begin
      if (func_q == 3'(k + 1)) rd_sel = sram_din[k*DATA_W +: DATA_W];
    end
  end

  // Access sequencer: state, SRAM strobes and the ack/err handshake.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples the pre-edge values of the others.
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wr_q      <= 1'b0;
      func_q    <= '0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      sram_csn  <= '1;
      sram_wen  <= 1'b1;
      sram_oen  <= 1'b1;
      sram_addr <= '0;
      sram_dout <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q   <= wr;
            func_q <= cmd52_53_func_num;
            busy   <= 1'b1;
            if (req_valid) begin
              state     <= SETUP;
              err_q     <= 1'b0;
              sram_addr <= addr;
              sram_dout <= wdata;
              sram_csn  <= csn_dec;
            end else begin
              // Rejected: report straight away; a rejected read clears rdata.
              state <= DONE;
              err_q <= 1'b1;
              if (!wr) rdata <= '0;
            end
          end
        end
        SETUP: begin
          if (sram_onn) begin
            state    <= DONE;
            err_q    <= 1'b1;
            sram_csn <= '1;
          end else begin
            state    <= ACCESS;
            wait_cnt <= 4'(WAIT_CYCLES - 1);
            sram_wen <= ~wr_q;
            sram_oen <= wr_q;
          end
        end
        ACCESS: begin
          // The global disable wins even on the final strobe cycle; rdata is left untouched.
          if (sram_onn) begin
            state    <= DONE;
            err_q    <= 1'b1;
            sram_csn <= '1;
            sram_wen <= 1'b1;
            sram_oen <= 1'b1;
          end else if (wait_cnt == 4'd0) begin
            if (!wr_q) rdata <= rd_sel;
            state    <= DONE;
            sram_csn <= '1;
            sram_wen <= 1'b1;
            sram_oen <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack   <= 1'b1;
          err   <= err_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
